// File: rtl/div_pkg.sv
// Shared types and constants for the FP32 iterative mantissa divider sequencer.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } div_seq_state_t;

    localparam int DIV_FP32_ITERS = 26;
    localparam int DIV_CNT_W      = 8;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration down counter: load has priority over decrement, holds otherwise,
// and never wraps below zero.
module div_iter_counter
    import div_pkg::*;
#(
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_data,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             is_one
);

    logic [CNT_W-1:0] cnt_r;

    // Counter register with load-over-decrement priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (ld) begin
            cnt_r <= ld_data;
        end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt    = cnt_r;
    assign is_one = (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/div_iter_sequencer.sv
// Control FSM for the FP32 restoring mantissa divider (IDLE/LOAD/ITER/DONE).
// Optional abort support is compiled in with DIV_SEQ_ABORT_EN.
module div_iter_sequencer
    import div_pkg::*;
#(
    parameter int ITERS = DIV_FP32_ITERS,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             start_ready,
    input  logic             div_by_zero,
    input  logic             rem_neg,
    output logic             ld_op,
    output logic             step_en,
    output logic             q_bit,
    output logic             restore,
    output logic [CNT_W-1:0] iter_cnt,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
`ifdef DIV_SEQ_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             dz_flag
);

    div_seq_state_t   state_r;
    div_seq_state_t   state_s;
    logic             cnt_ld_s;
    logic             cnt_dec_s;
    logic [CNT_W-1:0] cnt_data_s;
    logic             cnt_is_one_s;
    logic             abort_s;
    logic             dz_flag_r;

`ifdef DIV_SEQ_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    div_iter_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .ld      (cnt_ld_s),
        .ld_data (cnt_data_s),
        .dec     (cnt_dec_s),
        .cnt     (iter_cnt),
        .is_one  (cnt_is_one_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and counter control; an abort reloads the counter with zero.
    always_comb begin
        state_s    = state_r;
        cnt_ld_s   = 1'b0;
        cnt_dec_s  = 1'b0;
        cnt_data_s = CNT_W'(ITERS);
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = div_by_zero ? DONE : LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                cnt_ld_s = 1'b1;
                if (abort_s) begin
                    cnt_data_s = {CNT_W{1'b0}};
                    state_s    = DONE;
                end else begin
                    state_s    = ITER;
                end
            end
            ITER: begin
                if (abort_s) begin
                    cnt_ld_s   = 1'b1;
                    cnt_data_s = {CNT_W{1'b0}};
                    state_s    = DONE;
                end else begin
                    cnt_dec_s = 1'b1;
                    state_s   = cnt_is_one_s ? DONE : ITER;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Divide-by-zero flag lives from the zero-divisor start until the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            dz_flag_r <= 1'b0;
        end else if ((state_r == IDLE) && start && div_by_zero) begin
            dz_flag_r <= 1'b1;
        end else if ((state_r == DONE) && res_ready) begin
            dz_flag_r <= 1'b0;
        end else begin
            dz_flag_r <= dz_flag_r;
        end
    end

`ifdef DIV_SEQ_ABORT_EN
    logic aborted_r;

    // Abort marker accompanies the early result until the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            aborted_r <= 1'b0;
        end else if (((state_r == LOAD) || (state_r == ITER)) && abort) begin
            aborted_r <= 1'b1;
        end else if ((state_r == DONE) && res_ready) begin
            aborted_r <= 1'b0;
        end else begin
            aborted_r <= aborted_r;
        end
    end

    assign aborted = aborted_r;
`endif

    assign start_ready = (state_r == IDLE);
    assign ld_op       = (state_r == LOAD);
    assign step_en     = (state_r == ITER);
    assign q_bit       = step_en & ~rem_neg;
    assign restore     = step_en & rem_neg;
    assign busy        = (state_r != IDLE);
    assign res_valid   = (state_r == DONE);
    assign dz_flag     = dz_flag_r;

endmodule

// File: tb/tb_div_iter_sequencer.sv
// Self-checking bench: a 26-step and a 1-step sequencer share randomized and
// directed stimulus and are compared every cycle against a job-timeline model.
module tb_div_iter_sequencer;

    localparam int NDUT = 2;
    localparam int IT0  = 26;
    localparam int IT1  = 1;

    logic clk = 1'b0;
    logic rst, start, div_by_zero, rem_neg, res_ready;
    logic abort;
    logic       sr [NDUT];
    logic       ld [NDUT];
    logic       st [NDUT];
    logic       qb [NDUT];
    logic       rs [NDUT];
    logic       bz [NDUT];
    logic       rv [NDUT];
    logic       dz [NDUT];
    logic       ab [NDUT];
    logic [7:0] ic [NDUT];

    int checks = 0;
    int errors = 0;
    int cycnum = 0;

    // Model: age 0 = idle, 1 = load cycle, 2..its+1 = step cycles; done separate.
    int its   [NDUT] = '{IT0, IT1};
    int age   [NDUT] = '{0, 0};
    bit done  [NDUT] = '{1'b0, 1'b0};
    bit dzm   [NDUT] = '{1'b0, 1'b0};
    bit abm   [NDUT] = '{1'b0, 1'b0};
    int steps [NDUT] = '{0, 0};
    int loads [NDUT] = '{0, 0};
    int rv_rise [NDUT] = '{0, 0};
    bit rv_prev [NDUT] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    div_iter_sequencer #(.ITERS(IT0), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .start_ready(sr[0]),
        .div_by_zero(div_by_zero), .rem_neg(rem_neg), .ld_op(ld[0]),
        .step_en(st[0]), .q_bit(qb[0]), .restore(rs[0]), .iter_cnt(ic[0]),
        .busy(bz[0]), .res_valid(rv[0]), .res_ready(res_ready),
`ifdef DIV_SEQ_ABORT_EN
        .abort(abort), .aborted(ab[0]),
`endif
        .dz_flag(dz[0])
    );

    div_iter_sequencer #(.ITERS(IT1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .start_ready(sr[1]),
        .div_by_zero(div_by_zero), .rem_neg(rem_neg), .ld_op(ld[1]),
        .step_en(st[1]), .q_bit(qb[1]), .restore(rs[1]), .iter_cnt(ic[1]),
        .busy(bz[1]), .res_valid(rv[1]), .res_ready(res_ready),
`ifdef DIV_SEQ_ABORT_EN
        .abort(abort), .aborted(ab[1]),
`endif
        .dz_flag(dz[1])
    );

`ifndef DIV_SEQ_ABORT_EN
    assign ab[0] = 1'b0;
    assign ab[1] = 1'b0;
`endif

    task automatic chk(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, cycnum, act, exp);
        end
    endtask

    // Compare all outputs against the model, then advance the model with the
    // inputs that the next rising edge will sample.
    task automatic model_step();
        for (int d = 0; d < NDUT; d++) begin
            bit idle_e, ld_e, st_e;
            int cnt_e;
            idle_e = !done[d] && (age[d] == 0);
            ld_e   = !done[d] && (age[d] == 1);
            st_e   = !done[d] && (age[d] >= 2);
            cnt_e  = st_e ? (its[d] - age[d] + 2) : 0;
            chk("start_ready", d, int'(sr[d]), int'(idle_e));
            chk("ld_op",       d, int'(ld[d]), int'(ld_e));
            chk("step_en",     d, int'(st[d]), int'(st_e));
            chk("q_bit",       d, int'(qb[d]), int'(st_e && !rem_neg));
            chk("restore",     d, int'(rs[d]), int'(st_e && rem_neg));
            chk("iter_cnt",    d, int'(ic[d]), cnt_e);
            chk("busy",        d, int'(bz[d]), int'(!idle_e));
            chk("res_valid",   d, int'(rv[d]), int'(done[d]));
            chk("dz_flag",     d, int'(dz[d]), int'(done[d] && dzm[d]));
`ifdef DIV_SEQ_ABORT_EN
            chk("aborted",     d, int'(ab[d]), int'(done[d] && abm[d]));
`endif
            if (st[d]) steps[d]++;
            if (ld[d]) loads[d]++;
            if (rv[d] && !rv_prev[d]) rv_rise[d] = cycnum;
            rv_prev[d] = rv[d];

            if (rst) begin
                age[d] = 0; done[d] = 1'b0; dzm[d] = 1'b0; abm[d] = 1'b0;
            end else if (done[d]) begin
                if (res_ready) begin
                    done[d] = 1'b0; dzm[d] = 1'b0; abm[d] = 1'b0;
                end
            end else if (age[d] > 0) begin
`ifdef DIV_SEQ_ABORT_EN
                if (abort) begin
                    age[d] = 0; done[d] = 1'b1; abm[d] = 1'b1;
                end else
`endif
                begin
                    age[d]++;
                    if (age[d] == its[d] + 2) begin
                        age[d] = 0; done[d] = 1'b1;
                    end
                end
            end else if (start) begin
                if (div_by_zero) begin
                    done[d] = 1'b1; dzm[d] = 1'b1;
                end else begin
                    age[d] = 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #2;
        cycnum++;
    endtask

    // Full divide from idle: pins latency and step counts of both builds.
    task automatic run_full();
        int t0, s0, s1, n;
        s0 = steps[0]; s1 = steps[1];
        t0 = cycnum;
        start = 1'b1; div_by_zero = 1'b0;
        tick();
        start = 1'b0;
        n = 0;
        while (!rv[0] && n < 100) begin
            rem_neg = ~rem_neg;
            tick();
            n++;
        end
        chk("latency_26", 0, cycnum - t0, 28);
        chk("steps_26",   0, steps[0] - s0, 26);
        chk("latency_1",  1, rv_rise[1] - t0, 3);
        chk("steps_1",    1, steps[1] - s1, 1);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        int t0, s0, l0;
        rst = 1'b1; start = 1'b0; div_by_zero = 1'b0; rem_neg = 1'b0;
        res_ready = 1'b0; abort = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        run_full();
        // Backpressure with an ignored start inside the window.
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
        end
        start = 1'b0;
        chk("held_valid", 0, int'(rv[0]), 1);
        handshake();
        chk("idle_after_hs", 0, int'(sr[0]), 1);

        // Zero divisor short-circuit.
        s0 = steps[0]; l0 = loads[0];
        start = 1'b1; div_by_zero = 1'b1;
        tick();
        start = 1'b0; div_by_zero = 1'b0;
        chk("dz_valid", 0, int'(rv[0]), 1);
        chk("dz_flag_set", 0, int'(dz[0]), 1);
        tick();
        chk("dz_no_steps", 0, steps[0] - s0, 0);
        chk("dz_no_loads", 0, loads[0] - l0, 0);
        handshake();
        chk("dz_cleared", 0, int'(dz[0]), 0);

        // Reset in the 10th step cycle, then a clean full divide.
        t0 = cycnum;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cycnum < t0 + 11) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_idle", 0, int'(sr[0]), 1);
        chk("rst_cnt",  0, int'(ic[0]), 0);
        chk("rst_busy", 0, int'(bz[0]), 0);
        chk("rst_valid", 0, int'(rv[0]), 0);
        run_full();
        handshake();

`ifdef DIV_SEQ_ABORT_EN
        // Abort in the 4th step cycle.
        t0 = cycnum;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cycnum < t0 + 5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", 0, int'(rv[0]), 1);
        chk("abort_flag",  0, int'(ab[0]), 1);
        chk("abort_cnt",   0, int'(ic[0]), 0);
        handshake();
`endif

        for (int i = 0; i < 600; i++) begin
            start       = ($urandom_range(0, 3) == 0);
            div_by_zero = ($urandom_range(0, 7) == 0);
            rem_neg     = $urandom_range(0, 1) == 1;
            res_ready   = $urandom_range(0, 1) == 1;
            rst         = ($urandom_range(0, 96) == 0);
            abort       = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_iter_sequencer.md
Name: div_iter_sequencer

Overview:
Control FSM for the FP32 iterative mantissa divider. It accepts a start request, loads the operand registers, then steps the restoring shift/subtract datapath once per cycle for a fixed iteration count. It presents the result with a valid/ready handshake and short-circuits divide-by-zero. The block sits between the FP32 divide front-end (unpack/exception logic) and the 32x32 divider datapath.

Parameters:
ITERS, 26, quotient bits produced per divide (24 mantissa + guard + round); legal range 1..2**CNT_W-1
CNT_W, 8, width of the internal iteration counter and of iter_cnt

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new divide; sampled only when start_ready=1
start_ready  output  1  high only in IDLE
div_by_zero  input  1  divisor mantissa zero; sampled together with start
rem_neg  input  1  sign of current trial remainder from datapath (1 = negative)
ld_op  output  1  one-cycle load strobe for dividend/divisor/remainder registers
step_en  output  1  datapath shift/subtract enable, one per iteration
q_bit  output  1  quotient bit for the current step = ~rem_neg when step_en, else 0
restore  output  1  restore remainder = rem_neg when step_en, else 0
iter_cnt  output  CNT_W  iterations remaining, including the current one
busy  output  1  high in LOAD, ITER, DONE
res_valid  output  1  result (quotient/remainder registers and dz_flag) valid
res_ready  input  1  consumer accepts result
dz_flag  output  1  result is divide-by-zero; valid while res_valid=1

Behaviour:
- States: IDLE, LOAD, ITER, DONE. Binary encoding is sufficient.
- Reset (rst=1 at edge) from any state: state=IDLE, iter_cnt=0, dz_flag=0. All strobes, busy and res_valid deassert the same edge. rst overrides start.
- IDLE: start_ready=1. On start=1 with div_by_zero=0, go to LOAD. On start=1 with div_by_zero=1, go directly to DONE and set dz_flag=1. No ld_op or step_en pulses in the zero-divisor case.
- LOAD (1 cycle): ld_op=1 and iter_cnt loads ITERS. Next state is ITER.
- ITER: step_en=1 every cycle and iter_cnt decrements by 1 per cycle. When iter_cnt==1, the step is taken and the next state is DONE with iter_cnt=0. Exactly ITERS step_en cycles occur; no gaps; no wrap below 0.
- DONE: res_valid=1. Hold all datapath controls low. On res_ready=1, go to IDLE and clear dz_flag. res_valid stays high indefinitely under backpressure.
- Latency: start accepted at edge N gives res_valid from edge N+ITERS+2. Zero-divisor latency is N+1.
- start while not in IDLE is ignored and not queued. Back-to-back operation: a start in the first IDLE cycle after the DONE handshake is accepted, giving a minimum of one IDLE cycle between jobs.
- ld_op, step_en and res_valid are mutually exclusive.
- rem_neg is ignored outside ITER.
- Counter is a synchronous down counter with load priority over decrement, and it holds when neither load nor decrement is active.

Optional Feature:
Macro DIV_SEQ_ABORT_EN.
- Defined: extra input abort (1 bit). abort=1 in LOAD or ITER forces DONE next edge with iter_cnt=0 and dz_flag=0. An extra output aborted=1 accompanies that res_valid and clears on the handshake. abort has no effect in IDLE or DONE. rst has priority over abort.
- Undefined: neither port exists, and every divide runs the full ITERS steps.

Decomposition:
- Shared package div_pkg:
  - state enum div_seq_state_t (IDLE, LOAD, ITER, DONE)
  - constant DIV_FP32_ITERS = 26
  - constant DIV_CNT_W = 8
- One sub-module: div_iter_counter (CNT_W-bit synchronous down counter; inputs ld, ld_data, dec; outputs cnt, is_one), driven by the FSM.

Test Plan:
- ITERS=26, start pulse with div_by_zero=0 -> ld_op one cycle later; exactly 26 contiguous step_en cycles with iter_cnt 26..1; res_valid from cycle 28; dz_flag=0.
- rem_neg toggling 1,0,1,0... during ITER -> q_bit 0,1,0,1... and restore 1,0,1,0...; both 0 outside ITER.
- start with div_by_zero=1 -> res_valid and dz_flag next cycle; zero ld_op and step_en pulses; dz_flag clears after res_ready.
- res_ready held low 5 cycles in DONE, and start pulsed during that window -> res_valid held; start ignored; IDLE one cycle after res_ready=1.
- rst=1 at the 10th ITER cycle -> next edge IDLE, iter_cnt=0, busy=0, no res_valid. A subsequent start yields a full 26-step divide.
- ITERS=1 build -> exactly one step_en cycle; res_valid 3 cycles after start. With DIV_SEQ_ABORT_EN, abort in ITER cycle 4 -> DONE next edge with aborted=1.
